// File: rtl/bin_sched_ctrl.sv
// Bin load/update and backtrack sequencer for the SAT engine datapath.
// Arbitrates two request streams, issues start pulses and tracks the resident bin.
module bin_sched_ctrl #(
   parameter int WIDTH_BIN_I = 10,
   parameter int NUM_BINS    = 42,
   parameter int WIDTH_LVL   = 10,
   parameter int TIMEOUT     = 1024,
   parameter int WIDTH_TO    = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bin_req_valid_i,
   input  logic [WIDTH_BIN_I-1:0] bin_req_num_i,
   output logic                   bin_req_ready_o,
   input  logic                   bkt_req_valid_i,
   input  logic [WIDTH_LVL-1:0]   bkt_lvl_i,
   output logic                   bkt_req_ready_o,
   output logic                   start_load_update_o,
   output logic                   first_load_update_o,
   output logic [WIDTH_BIN_I-1:0] request_bin_num_o,
   input  logic                   load_update_done_i,
   output logic                   start_backtrack_o,
   output logic [WIDTH_LVL-1:0]   bkt_lvl_o,
   input  logic                   bkt_done_i,
   output logic [WIDTH_BIN_I-1:0] cur_bin_o,
   output logic                   cur_bin_valid_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_range_o,
   output logic                   err_timeout_o
);

   typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, BK_ISSUE, BK_WAIT, FIN} state_t;

   localparam logic [WIDTH_TO-1:0]    TO_LAST   = WIDTH_TO'(TIMEOUT - 1);
   localparam logic [WIDTH_BIN_I-1:0] BIN_LIMIT = WIDTH_BIN_I'(NUM_BINS);

   state_t              state;
   logic [WIDTH_TO-1:0] to_cnt;
   logic                bin_acc;
   logic                bkt_acc;
   logic                wait_expired;

   // Backtrack has strict priority, so a pending backtrack masks bin readiness.
   assign bkt_req_ready_o = (state == IDLE);
   assign bin_req_ready_o = (state == IDLE) && !bkt_req_valid_i;
   assign bkt_acc         = bkt_req_valid_i && bkt_req_ready_o;
   assign bin_acc         = bin_req_valid_i && bin_req_ready_o;
   assign wait_expired    = (to_cnt == TO_LAST);

   // NOTE: all state and outputs use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         to_cnt              <= '0;
         start_load_update_o <= 1'b0;
         first_load_update_o <= 1'b0;
         request_bin_num_o   <= '0;
         start_backtrack_o   <= 1'b0;
         bkt_lvl_o           <= '0;
         cur_bin_o           <= '0;
         cur_bin_valid_o     <= 1'b0;
         busy_o              <= 1'b0;
         done_o              <= 1'b0;
         err_range_o         <= 1'b0;
         err_timeout_o       <= 1'b0;
      end else begin
         start_load_update_o <= 1'b0;
         first_load_update_o <= 1'b0;
         start_backtrack_o   <= 1'b0;
         done_o              <= 1'b0;
         err_range_o         <= 1'b0;
         case (state)
            IDLE: begin
               if (bkt_acc) begin
                  bkt_lvl_o         <= bkt_lvl_i;
                  start_backtrack_o <= 1'b1;
                  to_cnt            <= '0;
                  state             <= BK_ISSUE;
                  busy_o            <= 1'b1;
               end else if (bin_acc) begin
                  if (bin_req_num_i >= BIN_LIMIT) begin
                     err_range_o <= 1'b1;
                  end else if (cur_bin_valid_o && bin_req_num_i == cur_bin_o) begin
                     done_o <= 1'b1;
                     state  <= FIN;
                     busy_o <= 1'b1;
                  end else begin
                     request_bin_num_o   <= bin_req_num_i;
                     start_load_update_o <= 1'b1;
                     first_load_update_o <= !cur_bin_valid_o;
                     to_cnt              <= '0;
                     state               <= LD_ISSUE;
                     busy_o              <= 1'b1;
                  end
               end
            end
            LD_ISSUE: state <= LD_WAIT;
            LD_WAIT: begin
               if (load_update_done_i) begin
                  cur_bin_o       <= request_bin_num_o;
                  cur_bin_valid_o <= 1'b1;
                  done_o          <= 1'b1;
                  state           <= FIN;
               end else if (wait_expired) begin
                  err_timeout_o   <= 1'b1;
                  cur_bin_valid_o <= 1'b0;
                  state           <= IDLE;
                  busy_o          <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            BK_ISSUE: state <= BK_WAIT;
            BK_WAIT: begin
               if (bkt_done_i) begin
                  done_o <= 1'b1;
                  state  <= FIN;
               end else if (wait_expired) begin
                  err_timeout_o   <= 1'b1;
                  cur_bin_valid_o <= 1'b0;
                  state           <= IDLE;
                  busy_o          <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            FIN: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_sched_ctrl.sv
// Scoreboard bench for bin_sched_ctrl: stimulus pushes expected events, a monitor pops them.
module tb_bin_sched_ctrl;

   typedef enum int {EV_LOAD, EV_BKT, EV_DONE, EV_ERANGE, EV_ETO} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       a;
      int       b;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bin_req_valid_i = 1'b0;
   logic [9:0] bin_req_num_i = '0;
   logic       bin_req_ready_o;
   logic       bkt_req_valid_i = 1'b0;
   logic [9:0] bkt_lvl_i = '0;
   logic       bkt_req_ready_o;
   logic       start_load_update_o;
   logic       first_load_update_o;
   logic [9:0] request_bin_num_o;
   logic       load_update_done_i = 1'b0;
   logic       start_backtrack_o;
   logic [9:0] bkt_lvl_o;
   logic       bkt_done_i = 1'b0;
   logic [9:0] cur_bin_o;
   logic       cur_bin_valid_o;
   logic       busy_o;
   logic       done_o;
   logic       err_range_o;
   logic       err_timeout_o;

   int  total = 0;
   int  bad = 0;
   ev_t exp_q[$];
   logic eto_q = 1'b0;

   bin_sched_ctrl dut (
      .clk(clk), .rst(rst),
      .bin_req_valid_i(bin_req_valid_i), .bin_req_num_i(bin_req_num_i),
      .bin_req_ready_o(bin_req_ready_o),
      .bkt_req_valid_i(bkt_req_valid_i), .bkt_lvl_i(bkt_lvl_i),
      .bkt_req_ready_o(bkt_req_ready_o),
      .start_load_update_o(start_load_update_o), .first_load_update_o(first_load_update_o),
      .request_bin_num_o(request_bin_num_o), .load_update_done_i(load_update_done_i),
      .start_backtrack_o(start_backtrack_o), .bkt_lvl_o(bkt_lvl_o), .bkt_done_i(bkt_done_i),
      .cur_bin_o(cur_bin_o), .cur_bin_valid_o(cur_bin_valid_o), .busy_o(busy_o),
      .done_o(done_o), .err_range_o(err_range_o), .err_timeout_o(err_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input ev_kind_t k, input int a, input int b);
      ev_t e;
      e.kind = k;
      e.a    = a;
      e.b    = b;
      exp_q.push_back(e);
   endtask

   task automatic observe(input ev_kind_t k, input int a, input int b, input string nm);
      ev_t e;
      if (exp_q.size() == 0) begin
         check({nm, "_unexpected"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check({nm, "_kind"}, int'(k), int'(e.kind));
         check({nm, "_a"}, a, e.a);
         check({nm, "_b"}, b, e.b);
      end
   endtask

   // Monitor: every pulse the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (start_load_update_o) observe(EV_LOAD, int'(request_bin_num_o), int'(first_load_update_o), "load");
         if (start_backtrack_o)   observe(EV_BKT, int'(bkt_lvl_o), int'(busy_o), "bkt");
         if (done_o)              observe(EV_DONE, int'(cur_bin_o), int'(cur_bin_valid_o), "done");
         if (err_range_o)         observe(EV_ERANGE, int'(cur_bin_o), int'(cur_bin_valid_o), "erange");
         if (err_timeout_o && !eto_q) observe(EV_ETO, int'(cur_bin_o), int'(cur_bin_valid_o), "etimeout");
      end
      eto_q <= err_timeout_o;
   end

   task automatic bin_req(input int num);
      int n = 0;
      @(negedge clk);
      bin_req_valid_i = 1'b1;
      bin_req_num_i   = 10'(num);
      #1;
      while (!bin_req_ready_o && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bin_req_ready_o) check("bin_req_accept_timeout", 0, 1);
      @(posedge clk);
      #1 bin_req_valid_i = 1'b0;
   endtask

   task automatic pulse_ld_done();
      @(negedge clk) load_update_done_i = 1'b1;
      @(negedge clk) load_update_done_i = 1'b0;
   endtask

   task automatic pulse_bk_done();
      @(negedge clk) bkt_done_i = 1'b1;
      @(negedge clk) bkt_done_i = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy_o && n < 50);
      if (busy_o) check({nm, "_idle_timeout"}, 1, 0);
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_start_ld"}, int'(start_load_update_o), 0);
      check({nm, "_first"}, int'(first_load_update_o), 0);
      check({nm, "_req_num"}, int'(request_bin_num_o), 0);
      check({nm, "_start_bk"}, int'(start_backtrack_o), 0);
      check({nm, "_bkt_lvl"}, int'(bkt_lvl_o), 0);
      check({nm, "_cur_bin"}, int'(cur_bin_o), 0);
      check({nm, "_cur_valid"}, int'(cur_bin_valid_o), 0);
      check({nm, "_busy"}, int'(busy_o), 0);
      check({nm, "_done"}, int'(done_o), 0);
      check({nm, "_erange"}, int'(err_range_o), 0);
      check({nm, "_etimeout"}, int'(err_timeout_o), 0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // First load into an empty residency.
      push(EV_LOAD, 3, 1);
      push(EV_DONE, 3, 1);
      bin_req(3);
      repeat (3) @(negedge clk);
      pulse_ld_done();
      wait_idle("load3");

      // Hit on the resident bin, then a reload with first=0.
      push(EV_DONE, 3, 1);
      bin_req(3);
      wait_idle("hit3");
      check("ready_after_hit", int'(bin_req_ready_o), 1);
      push(EV_LOAD, 7, 0);
      push(EV_DONE, 7, 1);
      bin_req(7);
      repeat (2) @(negedge clk);
      pulse_ld_done();
      wait_idle("load7");

      // Simultaneous requests: backtrack wins, bin request is held and served afterwards.
      push(EV_BKT, 12, 1);
      push(EV_DONE, 7, 1);
      push(EV_LOAD, 5, 0);
      push(EV_DONE, 5, 1);
      @(negedge clk);
      bkt_req_valid_i = 1'b1;
      bkt_lvl_i       = 10'd12;
      bin_req_valid_i = 1'b1;
      bin_req_num_i   = 10'd5;
      #1;
      check("both_bkt_ready", int'(bkt_req_ready_o), 1);
      check("both_bin_ready", int'(bin_req_ready_o), 0);
      @(posedge clk);
      #1 bkt_req_valid_i = 1'b0;
      bkt_lvl_i = 10'd99;
      repeat (2) @(negedge clk);
      pulse_bk_done();
      bin_req(5);
      repeat (2) @(negedge clk);
      pulse_ld_done();
      wait_idle("load5");
      check("bkt_lvl_held", int'(bkt_lvl_o), 12);

      // Out-of-range request.
      push(EV_ERANGE, 5, 1);
      bin_req(42);
      repeat (3) @(negedge clk);
      check("range_cur_bin", int'(cur_bin_o), 5);
      check("range_cur_valid", int'(cur_bin_valid_o), 1);
      check("range_busy", int'(busy_o), 0);

      // Timeout with the done withheld.
      push(EV_LOAD, 9, 0);
      push(EV_ETO, 5, 0);
      bin_req(9);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!err_timeout_o && n < 3000);
      check("timeout_latency", n, 1026);
      check("timeout_busy", int'(busy_o), 0);
      pulse_ld_done();
      repeat (3) @(negedge clk);
      check("stray_done_valid", int'(cur_bin_valid_o), 0);
      check("timeout_sticky", int'(err_timeout_o), 1);
      push(EV_LOAD, 4, 1);
      push(EV_DONE, 4, 1);
      bin_req(4);
      repeat (2) @(negedge clk);
      pulse_ld_done();
      wait_idle("load4");

      // Reset during LD_WAIT aborts silently.
      push(EV_LOAD, 6, 0);
      bin_req(6);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      rst = 1'b0;
      pulse_ld_done();
      repeat (4) @(negedge clk);
      check("post_reset_valid", int'(cur_bin_valid_o), 0);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
